axi_n2w_write_sequencer: RTL
============================

# axi_n2w_write_sequencer

Write-channel controller placed in front of the narrow-to-wide AXI width converter. It accepts one upstream write burst at a time, forwards the address phase downstream, and sequences the W beats. Per beat it produces the running beat address and size, which drive the converter's lane and strobe selection, and it generates the downstream WLAST. It then collects the single B response and returns it upstream. Only one transaction is outstanding at a time.

## Interface
- SOURCE_WIDTH, 64, upstream data width in bits (8..512, power of two)
- TARGET_WIDTH, 128, downstream data width in bits (must be greater than SOURCE_WIDTH)
- SOURCE_BYTES, SOURCE_WIDTH/8, derived
- aclk  in  1  single clock; all state updates on rising edge
- aresetn  in  1  asynchronous, active-low reset
- u_axi_awaddr/awsize/awlen/awburst  in  32/3/8/2  upstream write address
- u_axi_awvalid  in  1; u_axi_awready  out  1
- u_axi_wvalid  in  1; u_axi_wready  out  1; u_axi_wlast  in  1
- u_axi_bresp  out  2; u_axi_bvalid  out  1; u_axi_bready  in  1
- d_axi_awaddr/awsize/awlen/awburst  out  32/3/8/2  registered copy of the accepted AW
- d_axi_awvalid  out  1; d_axi_awready  in  1
- d_axi_wvalid  out  1; d_axi_wready  in  1; d_axi_wlast  out  1
- d_axi_bresp  in  2; d_axi_bvalid  in  1; d_axi_bready  out  1
- seq_beat_addr  out  32  address of the current W beat; drives converter lane select
- seq_beat_size  out  3  latched AWSIZE
- seq_busy  out  1  high in every state except IDLE
- seq_wlast_err  out  1  one-cycle pulse when upstream WLAST disagrees with the beat count

## Operation
- FSM states: IDLE, AW, DATA, RESP, BOUT.
- IDLE: u_axi_awready = aw_rdy register. On an AW handshake:
  - latch addr/size/len/burst
  - seq_beat_addr <= awaddr; beat_cnt <= 0
  - go to AW.
- AW: d_axi_awvalid = 1, driven from the latched registers. On d_axi_awready, go to DATA.
- DATA: combinational pass-through, d_axi_wvalid = u_axi_wvalid and u_axi_wready = d_axi_wready.
  - d_axi_wlast = (beat_cnt == len). It is generated internally and never copied from upstream.
  - On a beat handshake where beat_cnt == len: go to RESP.
  - On any other beat handshake: beat_cnt++ and seq_beat_addr advances.
- Address advance, with bytes = 1 << size:
  - INCR (01): next = (addr & ~(bytes-1)) + bytes, so unaligned start addresses become aligned from beat 2.
  - FIXED (00): address unchanged.
  - WRAP (10): wrap span = (len+1)*bytes; bits below log2(span) are incremented modulo span; upper bits are held.
  - Reserved (11): treated as INCR.
  - Arithmetic is 32-bit modulo 2^32; 0xFFFFFFFC + 4 wraps to 0.
- seq_wlast_err: pulses for one cycle on a beat handshake where u_axi_wlast != (beat_cnt == len). The burst continues using the internal count.
- RESP: d_axi_bready = 1. On d_axi_bvalid, latch bresp and go to BOUT.
- BOUT: u_axi_bvalid = 1 and u_axi_bresp = latched value, held stable until u_axi_bready. Then go to IDLE and set aw_rdy.
- No outputs are generated in other states. Upstream W beats are not accepted outside DATA: u_axi_wready = 0 and d_axi_wvalid = 0.
- Asynchronous reset mid-operation aborts the transaction immediately:
  - FSM returns to IDLE and all registers clear.
  - Any partial burst is abandoned, with no B response.

## Timing
- Reset values:
  - state = IDLE; aw_rdy = 0
  - all d_axi_aw* outputs = 0
  - seq_beat_addr = 0, seq_beat_size = 0
  - bresp register = 0
  - every valid/ready/last output = 0
  - seq_busy = 0, seq_wlast_err = 0
- aw_rdy becomes 1 on the first rising edge after aresetn deasserts.
- aw_rdy clears in the same edge as the AW handshake, so a back-to-back AW is never accepted.
- AW latency: upstream handshake at edge N gives d_axi_awvalid = 1 from cycle N+1.
- d_axi_awvalid is held, with stable payload, until d_axi_awready.
- DATA is entered the cycle after the downstream AW handshake. W valid/ready have zero added latency.
- seq_beat_addr is registered and updates on the edge of each beat handshake. It is stable for the whole beat.
- Last W handshake at edge M: d_axi_bready = 1 from cycle M+1.
- d_axi_bvalid sampled at edge K: u_axi_bvalid = 1 from cycle K+1.
- Upstream B handshake at edge P: u_axi_awready = 1 from cycle P+1.
- Minimum transaction length, no stalls: len+5 cycles from AW accept to awready re-asserting.

## Test plan
- Reset release → u_axi_awready 0 during reset, 1 one cycle after release; all other outputs 0.
- INCR, size=2, len=3, addr=0x1002 → seq_beat_addr 0x1002, 0x1004, 0x1008, 0x100C; d_axi_wlast only on beat 4; then d_axi_bresp=2'b10 appears upstream one cycle after d_axi_bvalid.
- WRAP, size=2, len=3, addr=0x0008 → seq_beat_addr 0x08, 0x0C, 0x00, 0x04; FIXED, len=2, addr=0x20 → 0x20 on all three beats.
- Upstream WLAST asserted on beat 2 of len=3 → seq_wlast_err pulses at beats 2 and 4; d_axi_wlast only on beat 4; state RESP after beat 4.
- Stalls: d_axi_awready low 3 cycles, d_axi_wready toggling, u_axi_bready low 2 cycles → d_axi_aw* payload and u_axi_bresp stable throughout; no beat lost or duplicated; second AW presented during DATA not accepted until after B.
- aresetn asserted in DATA after beat 1 → all outputs return to reset values asynchronously; a new burst after release completes normally.

Source files
------------

// File: rtl/axi_n2w_write_sequencer.sv
// Single-outstanding AXI write sequencer in front of the narrow-to-wide converter.
// Tracks per-beat address/size for lane selection and generates downstream WLAST from its own beat count.
module axi_n2w_write_sequencer #(
    parameter int SOURCE_WIDTH = 64,
    parameter int TARGET_WIDTH = 128,
    parameter int SOURCE_BYTES = SOURCE_WIDTH / 8
) (
    input  logic        aclk,
    input  logic        aresetn,

    input  logic [31:0] u_axi_awaddr,
    input  logic [2:0]  u_axi_awsize,
    input  logic [7:0]  u_axi_awlen,
    input  logic [1:0]  u_axi_awburst,
    input  logic        u_axi_awvalid,
    output logic        u_axi_awready,
    input  logic        u_axi_wvalid,
    output logic        u_axi_wready,
    input  logic        u_axi_wlast,
    output logic [1:0]  u_axi_bresp,
    output logic        u_axi_bvalid,
    input  logic        u_axi_bready,

    output logic [31:0] d_axi_awaddr,
    output logic [2:0]  d_axi_awsize,
    output logic [7:0]  d_axi_awlen,
    output logic [1:0]  d_axi_awburst,
    output logic        d_axi_awvalid,
    input  logic        d_axi_awready,
    output logic        d_axi_wvalid,
    input  logic        d_axi_wready,
    output logic        d_axi_wlast,
    input  logic [1:0]  d_axi_bresp,
    input  logic        d_axi_bvalid,
    output logic        d_axi_bready,

    output logic [31:0] seq_beat_addr,
    output logic [2:0]  seq_beat_size,
    output logic        seq_busy,
    output logic        seq_wlast_err
);
    // state | meaning
    // IDLE  | waiting for upstream AW (awready follows aw_rdy)
    // AW    | presenting the latched AW downstream
    // DATA  | W beats pass through, beat address tracked
    // RESP  | waiting for the downstream B
    // BOUT  | holding the B response upstream
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_AW   = 3'd1;
    localparam logic [2:0] ST_DATA = 3'd2;
    localparam logic [2:0] ST_RESP = 3'd3;
    localparam logic [2:0] ST_BOUT = 3'd4;

    generate
        if (TARGET_WIDTH <= SOURCE_WIDTH || SOURCE_BYTES * 8 != SOURCE_WIDTH) begin : g_bad_widths
            $error("axi_n2w_write_sequencer: target must be wider than source");
        end
    endgenerate

    logic [2:0]  state;
    logic        aw_rdy;
    logic [31:0] aw_addr_q;
    logic [2:0]  aw_size_q;
    logic [7:0]  aw_len_q;
    logic [1:0]  aw_burst_q;
    logic [31:0] beat_addr;
    logic [7:0]  beat_cnt;
    logic [1:0]  bresp_q;

    logic        aw_hs;
    logic        w_hs;
    logic        beat_last;
    logic [31:0] beat_bytes;
    logic [31:0] wrap_mask;
    logic [31:0] next_addr;

    assign aw_hs      = (state == ST_IDLE) && aw_rdy && u_axi_awvalid;
    assign w_hs       = (state == ST_DATA) && u_axi_wvalid && d_axi_wready;
    assign beat_last  = (beat_cnt == aw_len_q);
    assign beat_bytes = 32'd1 << aw_size_q;
    assign wrap_mask  = (({24'd0, aw_len_q} + 32'd1) << aw_size_q) - 32'd1;

    // INCR and the reserved encoding realign to the transfer size after the first beat
    always_comb begin
        next_addr = (beat_addr & ~(beat_bytes - 32'd1)) + beat_bytes;
        case (aw_burst_q)
            2'b00:   next_addr = beat_addr;
            2'b10:   next_addr = (beat_addr & ~wrap_mask) | ((beat_addr + beat_bytes) & wrap_mask);
            default: ;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= ST_IDLE;
            aw_rdy     <= 1'b0;
            aw_addr_q  <= 32'd0;
            aw_size_q  <= 3'd0;
            aw_len_q   <= 8'd0;
            aw_burst_q <= 2'd0;
            beat_addr  <= 32'd0;
            beat_cnt   <= 8'd0;
            bresp_q    <= 2'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (aw_hs) begin
                        aw_addr_q  <= u_axi_awaddr;
                        aw_size_q  <= u_axi_awsize;
                        aw_len_q   <= u_axi_awlen;
                        aw_burst_q <= u_axi_awburst;
                        beat_addr  <= u_axi_awaddr;
                        beat_cnt   <= 8'd0;
                        aw_rdy     <= 1'b0;
                        state      <= ST_AW;
                    end else begin
                        aw_rdy <= 1'b1;
                    end
                end
                ST_AW: begin
                    if (d_axi_awready) state <= ST_DATA;
                end
                ST_DATA: begin
                    if (w_hs) begin
                        if (beat_last) begin
                            state <= ST_RESP;
                        end else begin
                            beat_cnt  <= beat_cnt + 8'd1;
                            beat_addr <= next_addr;
                        end
                    end
                end
                ST_RESP: begin
                    if (d_axi_bvalid) begin
                        bresp_q <= d_axi_bresp;
                        state   <= ST_BOUT;
                    end
                end
                ST_BOUT: begin
                    if (u_axi_bready) begin
                        state  <= ST_IDLE;
                        aw_rdy <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign u_axi_awready = (state == ST_IDLE) && aw_rdy;
    assign d_axi_awvalid = (state == ST_AW);
    assign d_axi_awaddr  = aw_addr_q;
    assign d_axi_awsize  = aw_size_q;
    assign d_axi_awlen   = aw_len_q;
    assign d_axi_awburst = aw_burst_q;

    assign d_axi_wvalid  = (state == ST_DATA) && u_axi_wvalid;
    assign u_axi_wready  = (state == ST_DATA) && d_axi_wready;
    assign d_axi_wlast   = (state == ST_DATA) && beat_last;

    assign d_axi_bready  = (state == ST_RESP);
    assign u_axi_bvalid  = (state == ST_BOUT);
    assign u_axi_bresp   = (state == ST_BOUT) ? bresp_q : 2'b00;

    assign seq_beat_addr = beat_addr;
    assign seq_beat_size = aw_size_q;
    assign seq_busy      = (state != ST_IDLE);
    // upstream WLAST is only checked; the internal count always wins
    assign seq_wlast_err = w_hs && (u_axi_wlast != beat_last);

endmodule
